// File: rtl/stopwatch_display_if.sv
// Stopwatch digit inputs and multiplexed 7-segment display outputs.
// master drives the digits and controls; slave is the display block.
interface stopwatch_display_if;
  logic [3:0] minute;
  logic [3:0] tenSecond;
  logic [3:0] oneSecond;
  logic [3:0] tenthSecond;
  logic       lap;
  logic       blank;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frozen;

  modport master (
    output minute, tenSecond, oneSecond, tenthSecond, lap, blank,
    input  seg, dp, an, frozen
  );

  modport slave (
    input  minute, tenSecond, oneSecond, tenthSecond, lap, blank,
    output seg, dp, an, frozen
  );
endinterface

// File: rtl/stopwatch_display.sv
// Four-digit multiplexed M.SS.T display with lap freeze; input-to-seg latency 2 cycles.
// No backpressure: the scan free-runs and inputs are sampled every cycle while live.
module stopwatch_display #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                clk,
  input  logic                reset,
  stopwatch_display_if.slave  bus
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] TERM = CW'(REFRESH_DIV - 1);

  typedef enum logic {
    LIVE   = 1'b0,
    FROZEN = 1'b1
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   snap;
  logic          lap_prev;
  logic          lap_edge;
  logic          term;
  logic [3:0]    digit;

  logic [6:0]    seg_q;
  logic          dp_q;
  logic [3:0]    an_q;
  logic          frozen_q;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  assign lap_edge = bus.lap & ~lap_prev;
  assign term     = (cnt == TERM);

  always_comb begin
    state_d = state;
    if (lap_edge) begin
      state_d = (state == LIVE) ? FROZEN : LIVE;
    end
  end

  // idx 0 is the rightmost (tenths) digit, the low nibble of the snapshot.
  always_comb begin
    digit = 4'd0;
    case (idx)
      2'd0: digit = snap[3:0];
      2'd1: digit = snap[7:4];
      2'd2: digit = snap[11:8];
      2'd3: digit = snap[15:12];
      default: digit = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      idx      <= 2'd0;
      state    <= LIVE;
      snap     <= 16'h0000;
      lap_prev <= 1'b1;
      seg_q    <= 7'b1111111;
      dp_q     <= 1'b1;
      an_q     <= 4'b1111;
      frozen_q <= 1'b0;
    end else begin
      lap_prev <= bus.lap;

      if (term) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // The freezing edge itself still loads, so the frozen value is the one present at the lap press.
      if (state == LIVE) begin
        snap <= {bus.minute, bus.tenSecond, bus.oneSecond, bus.tenthSecond};
      end

      state    <= state_d;
      frozen_q <= (state_d == FROZEN);

      if (bus.blank) begin
        seg_q <= 7'b1111111;
        dp_q  <= 1'b1;
        an_q  <= 4'b1111;
      end else begin
        seg_q <= seg_decode(digit);
        dp_q  <= ~(idx[0]);
        an_q  <= ~(4'b0001 << idx);
      end
    end
  end

  assign bus.seg    = seg_q;
  assign bus.dp     = dp_q;
  assign bus.an     = an_q;
  assign bus.frozen = frozen_q;

endmodule

// File: doc/stopwatch_display.md
STOPWATCH_DISPLAY -- requirements
Module: stopwatch_display

Interface
REQ-001 Parameter: REFRESH_DIV, default 50000, clocks per digit slot; legal range 2..2^20.
REQ-002 Port: clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: minute  input  4  BCD minutes digit from the stopwatch counter.
REQ-005 Port: tenSecond  input  4  BCD tens-of-seconds digit.
REQ-006 Port: oneSecond  input  4  BCD seconds digit.
REQ-007 Port: tenthSecond  input  4  BCD tenths digit.
REQ-008 Port: lap  input  1  level input; each 0->1 transition toggles the lap freeze.
REQ-009 Port: blank  input  1  1 forces every digit dark.
REQ-010 Port: seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-011 Port: dp  output  1  active-low decimal point.
REQ-012 Port: an  output  4  active-low digit enables; an[0]=tenths (rightmost), an[3]=minutes.
REQ-013 Port: frozen  output  1  1 while the lap freeze is active.

Function
REQ-014 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; at terminal count the digit index SHALL advance 0->1->2->3->0.
REQ-015 Snapshot register (16 bits, {minute,tenSecond,oneSecond,tenthSecond}) SHALL load the inputs every cycle in state LIVE and hold in state FROZEN.
REQ-016 lap_prev SHALL register lap every cycle; a lap edge is lap=1 with lap_prev=0.
REQ-017 FSM: LIVE + lap edge -> FROZEN, and the snapshot loads the inputs on that same edge; FROZEN + lap edge -> LIVE; no other transitions.
REQ-018 frozen SHALL be a registered output, 1 exactly in state FROZEN.
REQ-019 seg, dp and an SHALL be registered: outputs at cycle n+1 are f(index_n, snapshot_n, blank_n).
REQ-020 Latency: input-to-seg latency SHALL be 2 cycles in LIVE.
REQ-021 Decode for digits 0..9 SHALL be: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
REQ-022 Non-BCD nibbles 10..15 SHALL display a dash (0111111).
REQ-023 an SHALL have exactly one bit low (the selected index) when blank=0, and SHALL be 1111 when blank=1.
REQ-024 dp SHALL be 0 when the index is 3 or 1, giving the M.SS.T format, and 1 otherwise.
REQ-025 dp SHALL be 1 whenever blank=1.
REQ-026 Refresh counter and index SHALL keep running while blank=1 or while FROZEN.
REQ-027 The lap edge and the refresh terminal count in the same cycle SHALL both take effect.
REQ-028 A lap level held high SHALL toggle the state once only.
REQ-029 lap already high at reset release SHALL NOT be taken as an edge, because lap_prev resets to 1.

Reset
REQ-030 While reset=1, the block SHALL set: counter=0, index=0, state=LIVE, snapshot=0, lap_prev=1.
REQ-031 While reset=1, the block SHALL drive: seg=1111111, dp=1, an=1111, frozen=0.
REQ-032 Reset SHALL override lap, blank and any in-progress freeze on the same edge.
REQ-033 On the first edge after reset release, outputs SHALL show index 0 with an=1110.

Verification (REFRESH_DIV=4)
REQ-034 Scan order: hold inputs 9,5,9,7 (M,tS,oS,t), release reset. Required: an sequence 1110,1101,1011,0111, each held 4 cycles, then repeats. seg sequence 1111000,0010000,0010010,0010000. dp=0 only on slots 1101 and 0111.
REQ-035 Lap freeze: inputs 0,1,2,3, pulse lap, then change inputs to 4,5,6,7. Required: frozen=1 and segments keep showing 0.1.2.3. A second lap pulse gives frozen=0, and 4.5.6.7 appears within 2 cycles of slot selection.
REQ-036 Lap held high: hold lap=1 for 20 cycles. Required: exactly one toggle. Assert reset with lap=1, then release. Required: frozen stays 0.
REQ-037 Non-BCD nibble: drive tenthSecond=4'hC. Required: seg=0111111 during an=1110.
REQ-038 Blank: assert blank mid-scan for 6 cycles. Required: an=1111 and dp=1 throughout. On release, the scan resumes at the index reached by the free-running counter, not at 0.
REQ-039 Reset mid-freeze: assert reset while frozen=1. Required: next edge gives frozen=0, an=1111, seg=1111111. After release, live values appear.
